// File: rtl/esop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | esop_pkg                                                                   |
// | Shared configuration, state encoding and cube record for the ESOP          |
// | cube expander. The localparams below are the single configuration point   |
// | of the block: NVARS, CHUNK_W and OUT_W size every port and register.       |
// |   NVARS   : number of input variables (table holds 2^NVARS bits)           |
// |   CHUNK_W : minterm bits expanded per cycle (power of two, divides table)  |
// |   OUT_W   : read-port word width (power of two, divides table)             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package esop_pkg;

  localparam int NVARS   = 8;
  localparam int CHUNK_W = 32;
  localparam int OUT_W   = 32;

  localparam int TT_BITS = 1 << NVARS;
  localparam int NCHUNK  = TT_BITS / CHUNK_W;
  localparam int NWORDS  = TT_BITS / OUT_W;

  // Index widths never collapse to zero, so a single-chunk or single-word
  // configuration still yields a legal 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int KW     = clog2_min1(NCHUNK);
  localparam int AW     = clog2_min1(NWORDS);
  localparam int CW_LOG = $clog2(CHUNK_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic [NVARS-1:0] care;
    logic [NVARS-1:0] pol;
    logic             last;
  } cube_t;

endpackage
`default_nettype wire

// File: rtl/esop_chunk_mask.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | esop_chunk_mask                                                            |
// | Combinational minterm mask for one chunk of the truth table. Bit j of the  |
// | mask is 1 when minterm m = k*CHUNK_W + j lies inside the cube.             |
// | Ports:                                                                     |
// |   care_i [NVARS]   : 1 = variable appears as a literal                     |
// |   pol_i  [NVARS]   : literal polarity (1 = xi, 0 = ~xi)                    |
// |   k_i    [KW]      : chunk index                                           |
// |   mask_o [CHUNK_W] : cube membership of each minterm in the chunk          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module esop_chunk_mask
  import esop_pkg::*;
(
  input  logic [NVARS-1:0]   care_i,
  input  logic [NVARS-1:0]   pol_i,
  input  logic [KW-1:0]      k_i,
  output logic [CHUNK_W-1:0] mask_o
);

  logic [NVARS-1:0] k_ext;
  assign k_ext = NVARS'(k_i);

  // CHUNK_W is a power of two, so the minterm number is the chunk index in
  // the upper bits concatenated with the bit position j in the lower bits.
  for (genvar j = 0; j < CHUNK_W; j++) begin : g_bit
    logic [NVARS-1:0] m;
    assign m         = (k_ext << CW_LOG) | NVARS'(j);
    assign mask_o[j] = &(~care_i | ~(m ^ pol_i));
  end

endmodule
`default_nettype wire

// File: rtl/esop_cube_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | esop_cube_expander                                                         |
// | Streams ESOP product cubes in over a valid/ready handshake and             |
// | XOR-accumulates each cube's minterms into a 2^NVARS-bit truth table, one   |
// | CHUNK_W-bit chunk per cycle. The table is read through a registered        |
// | word-addressed port.                                                       |
// | Ports:                                                                     |
// |   clk, rst              : clock, synchronous active-high reset             |
// |   start                 : clear table/count and enter ACCEPT               |
// |   cube_valid/ready      : cube handshake                                   |
// |   cube_care/pol/last    : cube literals and end-of-list flag               |
// |   busy, done            : status (ACCEPT|EXPAND, DONE)                     |
// |   rd_addr, rd_data      : word read port, 1-cycle latency                  |
// | Optional (macro ESOP_CUBE_CNT_EN):                                         |
// |   cube_count [16], cube_cnt_sat : saturating accepted-cube counter         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module esop_cube_expander
  import esop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cube_valid,
  output logic             cube_ready,
  input  logic [NVARS-1:0] cube_care,
  input  logic [NVARS-1:0] cube_pol,
  input  logic             cube_last,
  output logic             busy,
  output logic             done,
  input  logic [AW-1:0]    rd_addr,
  output logic [OUT_W-1:0] rd_data
`ifdef ESOP_CUBE_CNT_EN
  ,
  output logic [15:0]      cube_count,
  output logic             cube_cnt_sat
`endif
);

  state_e              state_q, state_d;
  cube_t               cube_q;
  logic [KW-1:0]       k_q;
  logic [TT_BITS-1:0]  tt_q;
  logic [OUT_W-1:0]    rd_data_q;
  logic [CHUNK_W-1:0]  mask;
  logic                xfer;
  logic                last_chunk;

  // Decoded from the state register rather than cube_ready so the handshake
  // does not form a loop through the next-state block. start wins over a
  // simultaneous transfer, which is dropped.
  assign xfer       = cube_valid & (state_q == ACCEPT) & ~start;
  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  esop_chunk_mask u_mask (
    .care_i (cube_q.care),
    .pol_i  (cube_q.pol),
    .k_i    (k_q),
    .mask_o (mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cube_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
      end
      ACCEPT: begin
        cube_ready = 1'b1;
        busy       = 1'b1;
        if (xfer) begin
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_d = cube_q.last ? DONE : ACCEPT;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (start) begin
      state_d = ACCEPT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q      <= '0;
      k_q       <= '0;
      cube_q    <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= tt_q[rd_addr*OUT_W +: OUT_W];
      if (start) begin
        tt_q <= '0;
        k_q  <= '0;
      end else begin
        if (xfer) begin
          cube_q.care <= cube_care;
          cube_q.pol  <= cube_pol;
          cube_q.last <= cube_last;
          k_q         <= '0;
        end
        if (state_q == EXPAND) begin
          tt_q[k_q*CHUNK_W +: CHUNK_W] <= tt_q[k_q*CHUNK_W +: CHUNK_W] ^ mask;
          // NCHUNK is a power of two, so the index wraps to 0 by itself.
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

  assign rd_data = rd_data_q;

`ifdef ESOP_CUBE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt_q <= '0;
    end else if (xfer && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cube_count   = cnt_q;
  assign cube_cnt_sat = (cnt_q == 16'hFFFF);
`endif

endmodule
`default_nettype wire

// File: tb/tb_esop_cube_expander.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_esop_cube_expander                                                      |
// | Directed self-checking bench for esop_cube_expander (default 8-variable    |
// | configuration, eight 32-bit read words).                                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_esop_cube_expander;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cube_valid;
  logic        cube_ready;
  logic [7:0]  cube_care;
  logic [7:0]  cube_pol;
  logic        cube_last;
  logic        busy;
  logic        done;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
`ifdef ESOP_CUBE_CNT_EN
  logic [15:0] cube_count;
  logic        cube_cnt_sat;
`endif

  int vectors    = 0;
  int miscompares = 0;

  esop_cube_expander dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cube_valid (cube_valid),
    .cube_ready (cube_ready),
    .cube_care  (cube_care),
    .cube_pol   (cube_pol),
    .cube_last  (cube_last),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
`ifdef ESOP_CUBE_CNT_EN
    ,
    .cube_count   (cube_count),
    .cube_cnt_sat (cube_cnt_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns one cycle after the accepting edge (first EXPAND cycle).
  task automatic send_cube(input logic [7:0] care, input logic [7:0] pol, input logic last);
    int n;
    n = 0;
    cube_valid = 1'b1;
    cube_care  = care;
    cube_pol   = pol;
    cube_last  = last;
    while (!cube_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    tick();
    cube_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic read_word(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    rd_addr = addr;
    tick();
    check(tag, rd_data, exp);
  endtask

  logic [31:0] exp_w;
  int          n_acc;
  int          low;

  initial begin
    rst = 1'b1; start = 1'b0; cube_valid = 1'b0;
    cube_care = '0; cube_pol = '0; cube_last = 1'b0; rd_addr = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready", {31'd0, cube_ready}, 32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_rdata", rd_data,             32'd0);
`ifdef ESOP_CUBE_CNT_EN
    check("rst_count", {16'd0, cube_count}, 32'd0);
`endif

    // care = 0 flips the whole table
    pulse_start();
    check("start_ready", {31'd0, cube_ready}, 32'd1);
    check("start_busy",  {31'd0, busy},       32'd1);
    send_cube(8'h00, 8'h00, 1'b1);
    check("exp_ready_low", {31'd0, cube_ready}, 32'd0);
    wait_done();
    for (int w = 0; w < 8; w++) read_word(3'(w), 32'hFFFF_FFFF, "full_flip");

    // ~x5: x5 is bit 0 of the word index, so even words are all ones
    pulse_start();
    send_cube(8'h20, 8'h00, 1'b1);
    wait_done();
    for (int w = 0; w < 8; w++) begin
      exp_w = (w % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      read_word(3'(w), exp_w, "not_x5");
    end

    // Full minterm 255, then the duplicate cancels it
    pulse_start();
    send_cube(8'hFF, 8'hFF, 1'b0);
    repeat (9) tick();
    check("dup_back_accept", {31'd0, cube_ready}, 32'd1);
    for (int w = 0; w < 8; w++) begin
      exp_w = (w == 7) ? 32'h8000_0000 : 32'h0;
      read_word(3'(w), exp_w, "minterm255");
    end
    send_cube(8'hFF, 8'hFF, 1'b1);
    wait_done();
    for (int w = 0; w < 8; w++) read_word(3'(w), 32'h0, "dup_cancel");

    // Backpressure: valid held high across x0, x1, x7
    pulse_start();
    n_acc = 0;
    low   = 0;
    cube_valid = 1'b1;
    cube_care = 8'h01; cube_pol = 8'h01; cube_last = 1'b0;
    for (int c = 0; c < 60 && n_acc < 3; c++) begin
      if (cube_ready) begin
        if (n_acc > 0) check("bp_gap", 32'(low), 32'd8);
        tick();
        n_acc++;
        low = 0;
        if (n_acc == 1) begin
          cube_care = 8'h02; cube_pol = 8'h02;
        end else if (n_acc == 2) begin
          cube_care = 8'h80; cube_pol = 8'h80; cube_last = 1'b1;
        end else begin
          cube_valid = 1'b0;
        end
      end else begin
        low++;
        tick();
      end
    end
    check("bp_accepts", 32'(n_acc), 32'd3);
    low = 0;
    while (!done && low < 20) begin
      low++;
      tick();
    end
    check("bp_done_latency", 32'(low), 32'd8);
    for (int w = 0; w < 8; w++) begin
      exp_w = (w < 4) ? 32'h6666_6666 : 32'h9999_9999;
      read_word(3'(w), exp_w, "bp_table");
    end
`ifdef ESOP_CUBE_CNT_EN
    check("bp_count", {16'd0, cube_count}, 32'd3);
    check("bp_sat",   {31'd0, cube_cnt_sat}, 32'd0);
`endif

    // start during chunk 4 discards the cube and clears the table
    pulse_start();
    send_cube(8'h00, 8'h00, 1'b0);
    repeat (4) tick();
    pulse_start();
    check("abort_ready", {31'd0, cube_ready}, 32'd1);
    check("abort_done",  {31'd0, done},       32'd0);
    for (int w = 0; w < 8; w++) read_word(3'(w), 32'h0, "abort_clear");
`ifdef ESOP_CUBE_CNT_EN
    check("abort_count0", {16'd0, cube_count}, 32'd0);
`endif
    send_cube(8'h20, 8'h20, 1'b1);
    wait_done();
    for (int w = 0; w < 8; w++) begin
      exp_w = (w % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
      read_word(3'(w), exp_w, "abort_next");
    end
`ifdef ESOP_CUBE_CNT_EN
    check("abort_count1", {16'd0, cube_count}, 32'd1);
`endif

    // rst in DONE
    rd_addr = 3'd1;
    tick();
    check("pre_rst_done", {31'd0, done}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_done_low",  {31'd0, done}, 32'd0);
    check("rst_rdata_low", rd_data,       32'd0);
    for (int c = 0; c < 4; c++) begin
      check("rst_idle_ready", {31'd0, cube_ready}, 32'd0);
      tick();
    end
    check("rst_table_gone", rd_data, 32'd0);

    // start has priority over a simultaneous transfer
    pulse_start();
    cube_valid = 1'b1; cube_care = 8'h00; cube_pol = 8'h00; cube_last = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cube_valid = 1'b0;
    check("prio_ready", {31'd0, cube_ready}, 32'd1);
    repeat (10) tick();
    check("prio_no_done", {31'd0, done}, 32'd0);
    read_word(3'd0, 32'h0, "prio_table");
`ifdef ESOP_CUBE_CNT_EN
    check("prio_count", {16'd0, cube_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
